ovf_range_store: RTL and testbench
==================================

Name: ovf_range_store

Overview:
Range store and lookup responder for the heap-overflow protection path. It receives completed overflow ranges, as [first,last] byte addresses, from the store-tracking unit, and keeps them in a circular table. It answers load-address queries with registered hit / first-byte / read-overflow flags, which the crash logic consumes. It sits beside the load/store unit and is the read end of the range-write interface.

Parameters:
NB_ENTRIES, 8, number of range entries; must be a power of two, 2..32
ADDR_W, 32, address width in bits

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
clear_i  in  1  synchronous clear of all entries
wr_en_i  in  1  write-range strobe, one cycle per range
wr_first_i  in  ADDR_W  first byte address of the range
wr_last_i  in  ADDR_W  last byte address of the range
wr_big_i  in  1  range came from a large write (count > 100)
lk_valid_i  in  1  lookup request
lk_addr_i  in  ADDR_W  address being loaded
lk_base_i  in  ADDR_W  base address of the current consecutive-load run
lk_valid_o  out  1  lookup response valid
lk_in_range_o  out  1  lk_addr inside some entry
lk_is_first_o  out  1  lk_addr equals the first address of the hit entry
lk_big_o  out  1  big flag of the hit entry
lk_rd_ovf_o  out  1  read overflow: base inside an entry, addr beyond its last
lk_idx_o  out  $clog2(NB_ENTRIES)  index of the hit entry
count_o  out  $clog2(NB_ENTRIES)+1  number of valid entries
full_o  out  1  count_o == NB_ENTRIES
ovwr_o  out  1  pulse: the oldest entry was evicted
wr_err_o  out  1  pulse: write rejected because first > last

Behaviour:
- Reset (rst_ni low, asynchronous): all entries invalid, wr_ptr=0, count=0. All outputs are 0.
- Entry state: first, last, big, valid. Entry age is implied by slot distance from wr_ptr.
- Write, evaluated on each cycle with wr_en_i=1:
  - first > last: rejected, nothing stored, wr_err_o=1 for 1 cycle.
  - Merge: merge when a valid entry overlaps or is adjacent to the new range, i.e. wr_first <= e.last+1 and wr_last+1 >= e.first. Compute the +1 in ADDR_W+1 bits so no wrap occurs at all-ones.
  - If a merge applies, only the newest matching entry is updated: first=min, last=max, big=OR. wr_ptr and count are unchanged.
  - No match and not full: store at wr_ptr; wr_ptr+1 mod NB_ENTRIES; count+1.
  - No match and full: overwrite the slot at wr_ptr (the oldest); wr_ptr+1; count stays; ovwr_o=1 for 1 cycle.
- Lookup latency is exactly 1 cycle. Request at cycle N gives lk_valid_o=1 at N+1. There is no backpressure and a new request is accepted every cycle.
- A lookup always sees table contents from before any write in the same cycle.
- Hit rule: e.valid && e.first <= lk_addr <= e.last, unsigned. With multiple hits, the newest entry wins and sets lk_idx_o, lk_is_first_o and lk_big_o.
- lk_rd_ovf_o=1 when some valid entry satisfies e.first <= lk_base <= e.last and lk_addr > e.last. This is independent of the hit rule.
- When lk_valid_i=0: lk_valid_o=0 next cycle and all lk_* flags are 0.
- clear_i: all entries invalid, wr_ptr=0, count=0, next cycle.
  - clear_i has priority over wr_en_i; a write in the same cycle is dropped.
  - A lookup in the clear cycle still answers from the old contents.
- count_o and full_o are registered and reflect the state after the last edge.

Decomposition:
- Package ovf_pkg: ovf_entry_t struct (first, last, big, valid), the default NB_ENTRIES, and an ovf_lookup_rsp_t struct holding the lk_* response fields.
- Sub-module ovf_range_match: purely combinational, one instance per entry. Inputs are the entry, addr and base. Outputs are hit, is_first, rd_ovf and merge_match.
- The top module handles newest-first priority selection (age relative to wr_ptr), pointers and registers.

Test Plan:
- Reset, then write [0x1000,0x101F] and look up 0x1010 -> next cycle: in_range=1, is_first=0, idx=0, count_o=1.
- Look up 0x1000 -> is_first=1. Look up 0x1020 -> in_range=0. Look up addr=0x1024 with base=0x1004 -> rd_ovf=1.
- Write [0x1020,0x102F] after [0x1000,0x101F] -> merged entry [0x1000,0x102F], count_o stays 1. Write [0x0,0xFFFFFFFF] also checks there is no +1 wrap.
- Write 9 disjoint ranges with NB_ENTRIES=8 -> full_o=1, ovwr_o pulses on the 9th write, first range no longer hits, 9th range hits at idx=0.
- Write [0x2000,0x1FFF] -> wr_err_o pulse, count unchanged. Same-cycle write plus lookup of the new range -> in_range=0, then a lookup one cycle later -> 1.
- clear_i asserted together with wr_en_i -> count_o=0 and no hits afterwards. Assert rst_ni low in the middle of a lookup -> lk_valid_o=0 immediately.

Source files
------------

// File: rtl/ovf_pkg.sv
// Shared types for the heap-overflow range store.
// Entry and lookup-response bundles used by the store and its matchers.
package ovf_pkg;

    localparam int unsigned OVF_NB_ENTRIES = 8;
    localparam int unsigned OVF_ADDR_W     = 32;
    // Entries are held at this width; narrower address ports zero-extend.
    localparam int unsigned OVF_AW         = 64;

    typedef struct packed {
        logic [OVF_AW-1:0] first;
        logic [OVF_AW-1:0] last;
        logic              big;
        logic              valid;
    } ovf_entry_t;

    // Lookup flags; the hit index is kept alongside at table width.
    typedef struct packed {
        logic valid;
        logic in_range;
        logic is_first;
        logic big;
        logic rd_ovf;
    } ovf_lookup_rsp_t;

endpackage

// File: rtl/ovf_range_store_match.sv
// Per-entry comparator for the overflow range store.
// Produces hit, first-byte, read-overflow and merge-candidate flags.
module ovf_range_match
    import ovf_pkg::*;
(
    input  ovf_entry_t        entry_i,
    input  logic [OVF_AW-1:0] addr_i,
    input  logic [OVF_AW-1:0] base_i,
    input  logic [OVF_AW-1:0] wr_first_i,
    input  logic [OVF_AW-1:0] wr_last_i,
    output logic              hit_o,
    output logic              is_first_o,
    output logic              rd_ovf_o,
    output logic              merge_match_o
);

    logic [OVF_AW:0] last_p1;
    logic [OVF_AW:0] wl_p1;

    // One extra bit so an all-ones bound does not wrap to zero.
    assign last_p1 = {1'b0, entry_i.last} + (OVF_AW + 1)'(1);
    assign wl_p1   = {1'b0, wr_last_i} + (OVF_AW + 1)'(1);

    assign hit_o = entry_i.valid
        && (entry_i.first <= addr_i)
        && (addr_i <= entry_i.last);

    assign is_first_o = hit_o && (addr_i == entry_i.first);

    assign rd_ovf_o = entry_i.valid
        && (entry_i.first <= base_i)
        && (base_i <= entry_i.last)
        && (addr_i > entry_i.last);

    // Overlapping or adjacent ranges are folded into one entry.
    assign merge_match_o = entry_i.valid
        && ({1'b0, wr_first_i} <= last_p1)
        && (wl_p1 >= {1'b0, entry_i.first});

endmodule

// File: rtl/ovf_range_store.sv
// Circular range table with newest-first lookup for overflow detection.
// Lookups see the table as it was before any same-cycle write.
module ovf_range_store
    import ovf_pkg::*;
#(
    parameter int unsigned NB_ENTRIES = OVF_NB_ENTRIES,
    parameter int unsigned ADDR_W     = OVF_ADDR_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_W-1:0]             wr_first_i,
    input  logic [ADDR_W-1:0]             wr_last_i,
    input  logic                          wr_big_i,
    input  logic                          lk_valid_i,
    input  logic [ADDR_W-1:0]             lk_addr_i,
    input  logic [ADDR_W-1:0]             lk_base_i,
    output logic                          lk_valid_o,
    output logic                          lk_in_range_o,
    output logic                          lk_is_first_o,
    output logic                          lk_big_o,
    output logic                          lk_rd_ovf_o,
    output logic [$clog2(NB_ENTRIES)-1:0] lk_idx_o,
    output logic [$clog2(NB_ENTRIES):0]   count_o,
    output logic                          full_o,
    output logic                          ovwr_o,
    output logic                          wr_err_o
);

    localparam int unsigned IDX_W = $clog2(NB_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    ovf_entry_t      ent_q [NB_ENTRIES];
    ovf_entry_t      ent_d [NB_ENTRIES];
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             ovwr_q, ovwr_d;
    logic             err_q, err_d;
    ovf_lookup_rsp_t  rsp_q, rsp_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [OVF_AW-1:0] wr_first, wr_last, lk_addr, lk_base;
    logic [NB_ENTRIES-1:0] hit, is_first, rd_ovf, mmatch;

    logic             hit_any, mrg_any;
    logic [IDX_W-1:0] hit_idx, mrg_idx, slot;

    assign wr_first = OVF_AW'(wr_first_i);
    assign wr_last  = OVF_AW'(wr_last_i);
    assign lk_addr  = OVF_AW'(lk_addr_i);
    assign lk_base  = OVF_AW'(lk_base_i);

    for (genvar i = 0; i < NB_ENTRIES; i++) begin : g_match
        ovf_range_match u_match (
            .entry_i      (ent_q[i]),
            .addr_i       (lk_addr),
            .base_i       (lk_base),
            .wr_first_i   (wr_first),
            .wr_last_i    (wr_last),
            .hit_o        (hit[i]),
            .is_first_o   (is_first[i]),
            .rd_ovf_o     (rd_ovf[i]),
            .merge_match_o(mmatch[i])
        );
    end

    // Walk slots from newest (ptr-1) to oldest; first match wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        mrg_any = 1'b0;
        mrg_idx = '0;
        slot    = '0;
        for (int k = 0; k < NB_ENTRIES; k++) begin
            slot = ptr_q - IDX_W'(k + 1);
            if (!hit_any && hit[slot]) begin
                hit_any = 1'b1;
                hit_idx = slot;
            end
            if (!mrg_any && mmatch[slot]) begin
                mrg_any = 1'b1;
                mrg_idx = slot;
            end
        end
    end

    // Lookup response, answered from the pre-write table.
    always_comb begin
        rsp_d.valid    = lk_valid_i;
        rsp_d.in_range = lk_valid_i && hit_any;
        rsp_d.is_first = lk_valid_i && hit_any && is_first[hit_idx];
        rsp_d.big      = lk_valid_i && hit_any && ent_q[hit_idx].big;
        rsp_d.rd_ovf   = lk_valid_i && (|rd_ovf);
        idx_d          = (lk_valid_i && hit_any) ? hit_idx : '0;
    end

    // Table update: clear, reject, merge, append or evict oldest.
    always_comb begin
        ent_d  = ent_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovwr_d = 1'b0;
        err_d  = 1'b0;
        if (clear_i) begin
            for (int i = 0; i < NB_ENTRIES; i++) ent_d[i] = '0;
            ptr_d = '0;
            cnt_d = '0;
        end else if (wr_en_i) begin
            if (wr_first > wr_last) begin
                err_d = 1'b1;
            end else if (mrg_any) begin
                if (wr_first < ent_q[mrg_idx].first)
                    ent_d[mrg_idx].first = wr_first;
                if (wr_last > ent_q[mrg_idx].last)
                    ent_d[mrg_idx].last = wr_last;
                ent_d[mrg_idx].big = ent_q[mrg_idx].big | wr_big_i;
            end else begin
                ent_d[ptr_q].first = wr_first;
                ent_d[ptr_q].last  = wr_last;
                ent_d[ptr_q].big   = wr_big_i;
                ent_d[ptr_q].valid = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (full_q) ovwr_d = 1'b1;
                else        cnt_d  = cnt_q + 1'b1;
            end
        end
        full_d = (cnt_d == CNT_W'(NB_ENTRIES));
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_ENTRIES; i++) ent_q[i] <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            ovwr_q <= 1'b0;
            err_q  <= 1'b0;
            rsp_q  <= '0;
            idx_q  <= '0;
        end else begin
            for (int i = 0; i < NB_ENTRIES; i++) ent_q[i] <= ent_d[i];
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            ovwr_q <= ovwr_d;
            err_q  <= err_d;
            rsp_q  <= rsp_d;
            idx_q  <= idx_d;
        end
    end

    assign lk_valid_o    = rsp_q.valid;
    assign lk_in_range_o = rsp_q.in_range;
    assign lk_is_first_o = rsp_q.is_first;
    assign lk_big_o      = rsp_q.big;
    assign lk_rd_ovf_o   = rsp_q.rd_ovf;
    assign lk_idx_o      = idx_q;
    assign count_o       = cnt_q;
    assign full_o        = full_q;
    assign ovwr_o        = ovwr_q;
    assign wr_err_o      = err_q;

endmodule

// File: tb/tb_ovf_range_store.sv
// Bench for ovf_range_store: directed scenarios plus random traffic
// checked against an age-stamped behavioural model of the range table.
module tb_ovf_range_store;

    localparam int N = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] wr_first_i = '0;
    logic [31:0] wr_last_i = '0;
    logic        wr_big_i = 1'b0;
    logic        lk_valid_i = 1'b0;
    logic [31:0] lk_addr_i = '0;
    logic [31:0] lk_base_i = '0;
    logic        lk_valid_o, lk_in_range_o, lk_is_first_o, lk_big_o;
    logic        lk_rd_ovf_o, full_o, ovwr_o, wr_err_o;
    logic [2:0]  lk_idx_o;
    logic [3:0]  count_o;

    int n_pass = 0;
    int n_total = 0;

    ovf_range_store #(.NB_ENTRIES(N), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .wr_en_i(wr_en_i), .wr_first_i(wr_first_i),
        .wr_last_i(wr_last_i), .wr_big_i(wr_big_i),
        .lk_valid_i(lk_valid_i), .lk_addr_i(lk_addr_i),
        .lk_base_i(lk_base_i), .lk_valid_o(lk_valid_o),
        .lk_in_range_o(lk_in_range_o), .lk_is_first_o(lk_is_first_o),
        .lk_big_o(lk_big_o), .lk_rd_ovf_o(lk_rd_ovf_o),
        .lk_idx_o(lk_idx_o), .count_o(count_o), .full_o(full_o),
        .ovwr_o(ovwr_o), .wr_err_o(wr_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: slots with a write sequence stamp; newest = max stamp.
    logic [31:0] m_first [N];
    logic [31:0] m_last  [N];
    bit          m_big   [N];
    bit          m_valid [N];
    int          m_stamp [N];
    int          m_cnt, m_seq;

    bit       e_valid, e_in, e_first, e_big, e_rdovf, e_full, e_ovwr, e_err;
    bit [2:0] e_idx;
    bit [3:0] e_cnt;

    function automatic logic [14:0] obs();
        return {lk_valid_o, lk_in_range_o, lk_is_first_o, lk_big_o,
                lk_rd_ovf_o, lk_idx_o, count_o, full_o, ovwr_o, wr_err_o};
    endfunction

    function automatic logic [14:0] expv();
        return {e_valid, e_in, e_first, e_big, e_rdovf, e_idx, e_cnt,
                e_full, e_ovwr, e_err};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_cnt = 0;
        {e_valid, e_in, e_first, e_big, e_rdovf, e_full, e_ovwr, e_err} = '0;
        e_idx = 0;
        e_cnt = 0;
    endtask

    task automatic model_step(input bit clr, input bit we,
                              input logic [31:0] wf, input logic [31:0] wl,
                              input bit wb, input bit lv,
                              input logic [31:0] la, input logic [31:0] lb);
        int best, slot;
        longint unsigned wf64, wl64, f64, l64;
        best = -1;
        {e_in, e_first, e_big, e_rdovf} = '0;
        e_idx = 0;
        e_valid = lv;
        for (int i = 0; i < N; i++) begin
            if (!m_valid[i]) continue;
            if (m_first[i] <= la && la <= m_last[i] && m_stamp[i] > best) begin
                best = m_stamp[i];
                e_in = 1;
                e_idx = 3'(i);
                e_first = (la == m_first[i]);
                e_big = m_big[i];
            end
            if (m_first[i] <= lb && lb <= m_last[i] && la > m_last[i])
                e_rdovf = 1;
        end
        if (!lv) begin
            {e_in, e_first, e_big, e_rdovf} = '0;
            e_idx = 0;
        end
        e_ovwr = 0;
        e_err = 0;
        if (clr) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_cnt = 0;
        end else if (we) begin
            wf64 = longint'(wf);
            wl64 = longint'(wl);
            if (wf > wl) begin
                e_err = 1;
            end else begin
                best = -1;
                slot = -1;
                for (int i = 0; i < N; i++) begin
                    f64 = longint'(m_first[i]);
                    l64 = longint'(m_last[i]);
                    if (m_valid[i] && wf64 <= l64 + 1 && wl64 + 1 >= f64
                        && m_stamp[i] > best) begin
                        best = m_stamp[i];
                        slot = i;
                    end
                end
                if (slot >= 0) begin
                    if (wf < m_first[slot]) m_first[slot] = wf;
                    if (wl > m_last[slot]) m_last[slot] = wl;
                    m_big[slot] = m_big[slot] | wb;
                end else begin
                    if (m_cnt < N) begin
                        slot = m_cnt;
                        m_cnt++;
                    end else begin
                        best = 32'h7fffffff;
                        for (int i = 0; i < N; i++)
                            if (m_stamp[i] < best) begin
                                best = m_stamp[i];
                                slot = i;
                            end
                        e_ovwr = 1;
                    end
                    m_first[slot] = wf;
                    m_last[slot] = wl;
                    m_big[slot] = wb;
                    m_valid[slot] = 1;
                    m_stamp[slot] = m_seq;
                    m_seq++;
                end
            end
        end
        e_cnt = 4'(m_cnt);
        e_full = (m_cnt == N);
    endtask

    task automatic drive(input bit clr, input bit we,
                         input logic [31:0] wf, input logic [31:0] wl,
                         input bit wb, input bit lv,
                         input logic [31:0] la, input logic [31:0] lb);
        @(negedge clk_i);
        clear_i = clr; wr_en_i = we; wr_first_i = wf; wr_last_i = wl;
        wr_big_i = wb; lk_valid_i = lv; lk_addr_i = la; lk_base_i = lb;
        model_step(clr, we, wf, wl, wb, lv, la, lb);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        m_seq = 0;
        #12;
        n_total++;
        if (obs() !== 15'h0) $display("FAIL reset: got %h want 0", obs());
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        drive(0, 1, 32'h1000, 32'h101F, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h1010, 0);
        n_total++;
        if (obs() !== expv() || !lk_in_range_o || lk_is_first_o
            || lk_idx_o !== 3'd0 || count_o !== 4'd1)
            $display("FAIL basic_hit: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h1000, 0);
        n_total++;
        if (obs() !== expv() || lk_is_first_o !== 1'b1)
            $display("FAIL is_first: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h1020, 0);
        n_total++;
        if (obs() !== expv() || lk_in_range_o !== 1'b0)
            $display("FAIL miss_after_last: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h1024, 32'h1004);
        n_total++;
        if (obs() !== expv() || lk_rd_ovf_o !== 1'b1)
            $display("FAIL rd_ovf: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_merge();
        drive(0, 1, 32'h1020, 32'h102F, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h102F, 0);
        n_total++;
        if (obs() !== expv() || count_o !== 4'd1 || !lk_in_range_o
            || !lk_big_o)
            $display("FAIL merge_adjacent: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 1, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
        n_total++;
        if (obs() !== expv() || count_o !== 4'd1 || !lk_in_range_o)
            $display("FAIL merge_allones: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h0, 0);
        n_total++;
        if (obs() !== expv() || !lk_is_first_o)
            $display("FAIL merge_low: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_overwrite();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 32'(i + 1) << 16, (32'(i + 1) << 16) + 32'hF,
                  0, 0, 0, 0);
            n_total++;
            if (obs() !== expv() || ovwr_o !== (i == 8))
                $display("FAIL fill_%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        n_total++;
        if (full_o !== 1'b1 || count_o !== 4'd8)
            $display("FAIL full: got %b/%0d want 1/8", full_o, count_o);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h10000, 0);
        n_total++;
        if (obs() !== expv() || lk_in_range_o !== 1'b0)
            $display("FAIL evicted: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h90008, 0);
        n_total++;
        if (obs() !== expv() || !lk_in_range_o || lk_idx_o !== 3'd0)
            $display("FAIL newest_idx0: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_err_and_same_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h100, 32'h1FF, 0, 0, 0, 0);
        drive(0, 1, 32'h2000, 32'h1FFF, 0, 0, 0, 0);
        n_total++;
        if (obs() !== expv() || wr_err_o !== 1'b1 || count_o !== 4'd1)
            $display("FAIL wr_err: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 1, 32'h3000, 32'h30FF, 0, 1, 32'h3010, 0);
        n_total++;
        if (obs() !== expv() || wr_err_o || lk_in_range_o !== 1'b0)
            $display("FAIL same_cycle: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h3010, 0);
        n_total++;
        if (obs() !== expv() || lk_in_range_o !== 1'b1)
            $display("FAIL next_cycle: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_clear();
        drive(1, 1, 32'h5000, 32'h50FF, 0, 1, 32'h3010, 0);
        n_total++;
        if (obs() !== expv() || count_o !== 4'd0 || !lk_in_range_o)
            $display("FAIL clear: got %h want %h", obs(), expv());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 32'h5010, 0);
        n_total++;
        if (obs() !== expv() || lk_in_range_o)
            $display("FAIL clear_nohit: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] f, l, a, b;
        bit clr, we, lv, wb;
        int errs;
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            f = $urandom_range(0, 16'hFFFF);
            l = f + $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) l = f - 1;
            if ($urandom_range(0, 31) == 0) begin
                f = 32'hFFFFFF00;
                l = 32'hFFFFFFFF;
            end
            a = $urandom_range(0, 16'hFFFF);
            b = a - $urandom_range(0, 96);
            clr = ($urandom_range(0, 99) == 0);
            we = $urandom_range(0, 1);
            wb = $urandom_range(0, 1);
            lv = ($urandom_range(0, 3) != 0);
            drive(clr, we, f, l, wb, lv, a, b);
            n_total++;
            if (obs() !== expv()) begin
                if (errs < 10)
                    $display("FAIL random_%0d: got %h want %h",
                             c, obs(), expv());
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_lookup();
        drive(0, 1, 32'h7000, 32'h70FF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h7010, 0);
        n_total++;
        if (lk_valid_o !== 1'b1 || lk_in_range_o !== 1'b1)
            $display("FAIL pre_reset: got %b%b want 11",
                     lk_valid_o, lk_in_range_o);
        else n_pass++;
        #2 rst_ni = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (obs() !== 15'h0) $display("FAIL async_reset: got %h want 0", obs());
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'h7010, 0);
        n_total++;
        if (obs() !== expv() || lk_in_range_o)
            $display("FAIL post_reset: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_merge();
        test_overwrite();
        test_err_and_same_cycle();
        test_clear();
        test_random();
        test_reset_mid_lookup();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
